data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter LINES, default 16, meaning number of one-word direct-mapped lines (power of two, 4..256).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cpu_adr  input  32  CPU byte address; bits [1:0] ignored.
REQ-005 SHALL have port cpu_wdata  input  32  CPU store data.
REQ-006 SHALL have ports cpu_read / cpu_write  input  1 each  CPU load / store request.
REQ-007 SHALL have port cpu_rdata  output  32  load data to the CPU.
REQ-008 SHALL have port cpu_stall  output  1  high while the CPU must hold its request.
REQ-009 SHALL have ports mem_adr  output  32  and mem_wdata  output  32  for the backing data memory.
REQ-010 SHALL have ports mem_read / mem_write  output  1 each  backing-memory requests.
REQ-011 SHALL have ports mem_rdata  input  32  and mem_ready  input  1  for the backing-memory response, ready = transfer complete this cycle.

Function
REQ-012 SHALL index with cpu_adr[2+log2(LINES)-1:2] and tag with the remaining upper bits; each line holds valid, tag and one data word.
REQ-013 SHALL use FSM states IDLE, RD_MISS, WR_THRU.
REQ-014 In IDLE, a read hit SHALL drive cpu_rdata combinationally from the line with cpu_stall=0 (zero added latency).
REQ-015 In IDLE, a read miss SHALL assert cpu_stall combinationally and enter RD_MISS next edge.
REQ-016 In RD_MISS, mem_read=1 and mem_adr={cpu_adr[31:2],2'b00} SHALL be held until mem_ready; on the mem_ready edge the line SHALL be filled (valid=1, tag, mem_rdata) and the FSM SHALL return to IDLE, where the request then hits.
REQ-017 A store SHALL be write-through, no-write-allocate: in IDLE cpu_stall=1 and the FSM enters WR_THRU; on a hit the line data SHALL be updated at that same edge.
REQ-018 In WR_THRU, mem_write=1 with mem_adr/mem_wdata from the CPU SHALL be held until mem_ready, then the FSM SHALL return to IDLE with cpu_stall=0 for one cycle so the CPU advances.
REQ-019 cpu_read and cpu_write both high SHALL be treated as a store.
REQ-020 With neither request asserted, mem_read, mem_write and cpu_stall SHALL be 0 and no state SHALL change.
REQ-021 mem_ready outside RD_MISS/WR_THRU SHALL be ignored.
REQ-022 cpu_rdata SHALL be 0 whenever no read hit is being returned.

Reset
REQ-023 rst high at an edge SHALL clear all valid bits, force IDLE and drive cpu_stall, mem_read, mem_write to 0 from the next cycle.
REQ-024 rst during RD_MISS or WR_THRU SHALL abandon the transfer without filling a line; a late mem_ready SHALL be ignored.

Configuration
REQ-025 With macro DCACHE_STATS_EN defined, the block SHALL add outputs hit_cnt and miss_cnt (32 each), counting read hits and read misses once per request, saturating at all-ones, cleared by rst.
REQ-026 Without DCACHE_STATS_EN, those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and default LINES constant.
REQ-028 The valid/tag/data storage SHALL be one sub-module, dcache_array, with one write port and one asynchronous read port.

Verification
REQ-029 After reset, read 0x40 with memory returning 0xDEADBEEF after 2 cycles -> stall 3 cycles, mem_read held, then cpu_rdata=0xDEADBEEF with stall=0; a repeat read hits with no mem_read.
REQ-030 Store 0x12345678 to cached 0x40 -> line updated, mem_write held until mem_ready; next read of 0x40 returns 0x12345678 without mem_read.
REQ-031 Store to uncached 0x80, then read 0x80 -> read misses (no allocate).
REQ-032 With LINES=16, read 0x40, then 0x80 (same index, different tag), then 0x40 -> three misses (conflict eviction).
REQ-033 Assert rst during RD_MISS, then pulse mem_ready -> no line filled, FSM in IDLE, mem_read=0.
REQ-034 With DCACHE_STATS_EN, sequence of REQ-029 -> hit_cnt=1, miss_cnt=1.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache.
//   state_t   : cache controller FSM states
//   LINES_DEF : default number of one-word lines
package data_cache_pkg;

  localparam int LINES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

endpackage

// File: rtl/data_cache_array.sv
// Line storage for the data cache: per-line valid bit, tag and one data word.
// One synchronous write port (always marks the line valid) and one
// asynchronous read port.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (clears valid bits only)
//   we, wr_idx          : write enable and line index to write
//   wr_tag, wr_data     : tag and data word stored on write
//   rd_idx              : line index to read
//   rd_valid/tag/data   : contents of line rd_idx (combinational)
module dcache_array #(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  // Only the valid bits need reset; tag and data are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (we) begin
      r_valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      r_tag[wr_idx]  <= wr_tag;
      r_data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = r_valid[rd_idx];
  assign rd_tag   = r_tag[rd_idx];
  assign rd_data  = r_data[rd_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line data cache. Reads allocate on miss;
// stores are write-through, no-write-allocate (a store hit also updates
// the line). Read hits return data combinationally with no stall.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cpu_adr, cpu_wdata       : CPU byte address (bits [1:0] ignored), store data
//   cpu_read, cpu_write      : CPU load / store request (both high = store)
//   cpu_rdata, cpu_stall     : load data (0 unless a hit is returned), hold request
//   mem_adr, mem_wdata       : backing memory word address / store data
//   mem_read, mem_write      : backing memory requests
//   mem_rdata, mem_ready     : backing memory response, ready = transfer done
//   hit_cnt, miss_cnt        : saturating read hit/miss counters, present only
//                              when macro DCACHE_STATS_EN is defined
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES = LINES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  state_t           r_state;
  logic             r_wr_done;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [31:0]      w_rd_data;
  logic             w_hit;
  logic             w_rd_req;
  logic             w_wr_start;
  logic             w_fill;
  logic             w_we;
  logic [31:0]      w_line_data;
  logic             w_unused;

  assign w_idx    = cpu_adr[IDX_W+1:2];
  assign w_tag    = cpu_adr[31:IDX_W+2];
  assign w_unused = &{1'b0, cpu_adr[1:0]};

  assign w_hit    = w_rd_valid && (w_rd_tag == w_tag);
  // A simultaneous read+write is a store, so a read request excludes write.
  assign w_rd_req = cpu_read && !cpu_write;

  // r_wr_done marks the single release cycle after a write-through, during
  // which the CPU still presents the finished store and must not restart it.
  assign w_wr_start  = (r_state == IDLE) && cpu_write && !r_wr_done;
  assign w_fill      = (r_state == RD_MISS) && mem_ready;
  assign w_we        = w_fill || (w_wr_start && w_hit);
  assign w_line_data = w_fill ? mem_rdata : cpu_wdata;

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .we       (w_we),
    .wr_idx   (w_idx),
    .wr_tag   (w_tag),
    .wr_data  (w_line_data),
    .rd_idx   (w_idx),
    .rd_valid (w_rd_valid),
    .rd_tag   (w_rd_tag),
    .rd_data  (w_rd_data)
  );

  assign mem_adr   = {cpu_adr[31:2], 2'b00};
  assign mem_wdata = cpu_wdata;

  // Outputs are decoded from state and the live request so a hit costs no
  // cycle and a miss stalls in the same cycle it is seen.
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_write) begin
          cpu_stall = !r_wr_done;
        end else if (cpu_read) begin
          if (w_hit) begin
            cpu_rdata = w_rd_data;
          end else begin
            cpu_stall = 1'b1;
          end
        end
      end
      RD_MISS: begin
        cpu_stall = 1'b1;
        mem_read  = 1'b1;
      end
      WR_THRU: begin
        cpu_stall = 1'b1;
        mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wr_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wr_done <= 1'b0;
          if (w_wr_start) begin
            r_state <= WR_THRU;
          end else if (w_rd_req && !w_hit) begin
            r_state <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (mem_ready) r_state <= IDLE;
        end
        WR_THRU: begin
          if (mem_ready) begin
            r_state   <= IDLE;
            r_wr_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_fill_done;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_hit_evt;
  logic        w_miss_evt;

  // The hit that completes a just-filled miss belongs to that miss request.
  assign w_hit_evt  = (r_state == IDLE) && w_rd_req && w_hit && !r_fill_done;
  assign w_miss_evt = (r_state == IDLE) && w_rd_req && !w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_done <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_fill_done <= w_fill;
      if (w_hit_evt && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_evt && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache (LINES=16): a per-cycle vector table covering
// miss/fill, hits, write-through, no-write-allocate, conflict eviction and
// read+write priority, followed by hand sequences for reset during a miss and
// (with DCACHE_STATS_EN) the hit/miss counters.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  data_cache #(.LINES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_adr   (cpu_adr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] mrd;
    logic        e_stall;
    logic [31:0] e_rdata;
    logic        e_mr;
    logic        e_mw;
    logic [31:0] e_madr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rd, input logic wr, input logic [31:0] adr,
                             input logic [31:0] wd, input logic rdy, input logic [31:0] mrd,
                             input logic es, input logic [31:0] erd, input logic emr,
                             input logic emw, input logic [31:0] emadr);
    vec_t r;
    r.rd = rd; r.wr = wr; r.adr = adr; r.wd = wd; r.rdy = rdy; r.mrd = mrd;
    r.e_stall = es; r.e_rdata = erd; r.e_mr = emr; r.e_mw = emw; r.e_madr = emadr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  // Drive one cycle's inputs after the falling edge and settle before checks.
  task automatic cyc(input logic rd, input logic wr, input logic [31:0] adr,
                     input logic [31:0] wd, input logic rdy, input logic [31:0] mrd);
    @(negedge clk);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_adr   = adr;
    cpu_wdata = wd;
    mem_ready = rdy;
    mem_rdata = mrd;
    #1;
  endtask

  initial begin
    rst = 1'b1; cpu_read = 0; cpu_write = 0; cpu_adr = 0; cpu_wdata = 0;
    mem_ready = 0; mem_rdata = 0;

    // cycle-by-cycle vectors: inputs, then stall, rdata, mem_read, mem_write, mem_adr
    tbl.push_back(v(0,0,32'h0, 32'h0,        0,32'h0,        0,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,0,32'h40,32'h0,        0,32'h0,        1,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,0,32'h40,32'h0,        0,32'h0,        1,32'h0,        1,0,32'h40));
    tbl.push_back(v(1,0,32'h40,32'h0,        1,32'hDEADBEEF, 1,32'h0,        1,0,32'h40));
    tbl.push_back(v(1,0,32'h40,32'h0,        0,32'h0,        0,32'hDEADBEEF, 0,0,32'h0));
    tbl.push_back(v(1,0,32'h40,32'h0,        0,32'h0,        0,32'hDEADBEEF, 0,0,32'h0));
    tbl.push_back(v(0,0,32'h0, 32'h0,        1,32'h00000BAD, 0,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,0,32'h40,32'h0,        0,32'h0,        0,32'hDEADBEEF, 0,0,32'h0));
    tbl.push_back(v(0,1,32'h40,32'h12345678, 0,32'h0,        1,32'h0,        0,0,32'h0));
    tbl.push_back(v(0,1,32'h40,32'h12345678, 0,32'h0,        1,32'h0,        0,1,32'h40));
    tbl.push_back(v(0,1,32'h40,32'h12345678, 1,32'h0,        1,32'h0,        0,1,32'h40));
    tbl.push_back(v(0,1,32'h40,32'h12345678, 0,32'h0,        0,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,0,32'h40,32'h0,        0,32'h0,        0,32'h12345678, 0,0,32'h0));
    tbl.push_back(v(0,1,32'h80,32'hAAAA5555, 0,32'h0,        1,32'h0,        0,0,32'h0));
    tbl.push_back(v(0,1,32'h80,32'hAAAA5555, 1,32'h0,        1,32'h0,        0,1,32'h80));
    tbl.push_back(v(0,1,32'h80,32'hAAAA5555, 0,32'h0,        0,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,0,32'h80,32'h0,        0,32'h0,        1,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,0,32'h80,32'h0,        1,32'h00000080, 1,32'h0,        1,0,32'h80));
    tbl.push_back(v(1,0,32'h80,32'h0,        0,32'h0,        0,32'h00000080, 0,0,32'h0));
    tbl.push_back(v(1,0,32'h40,32'h0,        0,32'h0,        1,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,0,32'h40,32'h0,        1,32'h00004040, 1,32'h0,        1,0,32'h40));
    tbl.push_back(v(1,0,32'h40,32'h0,        0,32'h0,        0,32'h00004040, 0,0,32'h0));
    tbl.push_back(v(1,0,32'h80,32'h0,        0,32'h0,        1,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,0,32'h80,32'h0,        1,32'h00008080, 1,32'h0,        1,0,32'h80));
    tbl.push_back(v(1,0,32'h80,32'h0,        0,32'h0,        0,32'h00008080, 0,0,32'h0));
    tbl.push_back(v(1,1,32'h80,32'h11112222, 0,32'h0,        1,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,1,32'h80,32'h11112222, 1,32'h0,        1,32'h0,        0,1,32'h80));
    tbl.push_back(v(1,1,32'h80,32'h11112222, 0,32'h0,        0,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,0,32'h80,32'h0,        0,32'h0,        0,32'h11112222, 0,0,32'h0));
    tbl.push_back(v(1,0,32'h47,32'h0,        0,32'h0,        1,32'h0,        0,0,32'h0));
    tbl.push_back(v(1,0,32'h47,32'h0,        1,32'h00000044, 1,32'h0,        1,0,32'h44));
    tbl.push_back(v(1,0,32'h47,32'h0,        0,32'h0,        0,32'h00000044, 0,0,32'h0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wd, tbl[i].rdy, tbl[i].mrd);
      chk($sformatf("row%0d stall", i),     {31'b0, cpu_stall}, {31'b0, tbl[i].e_stall});
      chk($sformatf("row%0d rdata", i),     cpu_rdata,          tbl[i].e_rdata);
      chk($sformatf("row%0d mem_read", i),  {31'b0, mem_read},  {31'b0, tbl[i].e_mr});
      chk($sformatf("row%0d mem_write", i), {31'b0, mem_write}, {31'b0, tbl[i].e_mw});
      if (tbl[i].e_mr || tbl[i].e_mw)
        chk($sformatf("row%0d mem_adr", i), mem_adr, tbl[i].e_madr);
      if (tbl[i].e_mw)
        chk($sformatf("row%0d mem_wdata", i), mem_wdata, tbl[i].wd);
    end

    // reset in the middle of a read miss, then a stray mem_ready
    cyc(1,0,32'h40,32'h0,0,32'h0);
    chk("rstmiss enter stall", {31'b0, cpu_stall}, 32'd1);
    cyc(1,0,32'h40,32'h0,0,32'h0);
    rst = 1'b1;
    chk("rstmiss in RD_MISS", {31'b0, mem_read}, 32'd1);
    cyc(0,0,32'h0,32'h0,1,32'h00000055);
    rst = 1'b0;
    #1;
    chk("rstmiss late rdy mem_read", {31'b0, mem_read},  32'd0);
    chk("rstmiss late rdy mem_write", {31'b0, mem_write}, 32'd0);
    chk("rstmiss late rdy stall",    {31'b0, cpu_stall}, 32'd0);
    cyc(1,0,32'h44,32'h0,0,32'h0);
    chk("rst cleared valid stall", {31'b0, cpu_stall}, 32'd1);
    chk("rst cleared valid rdata", cpu_rdata, 32'h0);
    chk("rst cleared idle mem_read", {31'b0, mem_read}, 32'd0);
    cyc(1,0,32'h44,32'h0,1,32'h00000099);
    chk("post-rst miss mem_read", {31'b0, mem_read}, 32'd1);
    chk("post-rst miss mem_adr", mem_adr, 32'h44);
    cyc(1,0,32'h44,32'h0,0,32'h0);
    chk("post-rst fill hit", cpu_rdata, 32'h99);
    chk("post-rst fill stall", {31'b0, cpu_stall}, 32'd0);
    cyc(1,0,32'h40,32'h0,0,32'h0);
    chk("abandoned line not filled", {31'b0, cpu_stall}, 32'd1);
    cyc(1,0,32'h40,32'h0,1,32'h0000040A);
    cyc(0,0,32'h0,32'h0,0,32'h0);

`ifdef DCACHE_STATS_EN
    rst = 1'b1;
    cyc(0,0,32'h0,32'h0,0,32'h0);
    rst = 1'b0;
    cyc(1,0,32'h40,32'h0,0,32'h0);
    cyc(1,0,32'h40,32'h0,0,32'h0);
    cyc(1,0,32'h40,32'h0,1,32'hDEADBEEF);
    cyc(1,0,32'h40,32'h0,0,32'h0);
    chk("stats fill rdata", cpu_rdata, 32'hDEADBEEF);
    cyc(1,0,32'h40,32'h0,0,32'h0);
    cyc(0,0,32'h0,32'h0,0,32'h0);
    chk("stats hit_cnt",  hit_cnt,  32'd1);
    chk("stats miss_cnt", miss_cnt, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
